// File: rtl/ct_vfalu_pkg.sv
// Shared definitions for the pipe-7 VFALU writeback slice.
//   - fflags bit positions inside the 5-bit ereg field
//   - default sizing parameters
//   - helper that returns the packed width of one writeback FIFO entry
package ct_vfalu_pkg;
  localparam int EREG_NV = 4;
  localparam int EREG_DZ = 3;
  localparam int EREG_OF = 2;
  localparam int EREG_UF = 1;
  localparam int EREG_NX = 0;
  localparam int EREG_W  = 5;
  localparam int FDATA_W = 64;

  localparam int DEF_DEPTH  = 4;
  localparam int DEF_PREG_W = 7;
  localparam int DEF_IID_W  = 7;

  // {preg, iid, freg_wen, ereg_wen, freg_data, ereg_data}
  function automatic int wb_entry_w(input int preg_w, input int iid_w);
    return preg_w + iid_w + 2 + FDATA_W + EREG_W;
  endfunction
endpackage

// File: rtl/ct_vfalu_wb_fifo.sv
// Synchronous FIFO used to buffer writeback entries.
// Ports:
//   clk_i, rst_b_i (sync active-low), flush_i (drop all contents)
//   push_i/din_i   write one entry at the tail
//   pop_i          retire the head (ignored when empty)
//   dout_o         head entry, read straight out of the storage registers
//   count_o        occupancy, full_o / empty_o status
module ct_vfalu_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_b_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        do_pop;

  assign do_pop  = pop_i & ~empty_o;
  assign count_d = count_q + CNT_W'(push_i) - CNT_W'(do_pop);

  // Pointers are exactly log2(DEPTH) bits, so increment wraps for free.
  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
endmodule

// File: rtl/ct_vfalu_wb_pipe7.sv
// Pipe-7 VFALU writeback stage.
// Carries EX1 control through EX2/EX3, joins it with the EX3 result, queues
// it in order, and drains the queue to the FP regfile write port on grant.
// Ports:
//   forever_cpuclk, cpurst_b (sync active-low), rtu_yy_xx_flush
//   dp_vfalu_ex1_pipex_*         op control issued into EX1
//   pipex_dp_ex3_vfalu_*_data    EX3 result and fflags
//   vfpu_wb_pipe7_grant          write port accepts the head entry
//   pipe7_wb_*                   head entry presented to the write port
//   pipe7_issue_rdy              EX1 may accept an op next cycle (credit)
module ct_vfalu_wb_pipe7
  import ct_vfalu_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PREG_W = DEF_PREG_W,
  parameter int IID_W  = DEF_IID_W
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              rtu_yy_xx_flush,
  input  logic              dp_vfalu_ex1_pipex_inst_vld,
  input  logic [PREG_W-1:0] dp_vfalu_ex1_pipex_preg,
  input  logic [IID_W-1:0]  dp_vfalu_ex1_pipex_iid,
  input  logic              dp_vfalu_ex1_pipex_freg_wen,
  input  logic              dp_vfalu_ex1_pipex_ereg_wen,
  input  logic [63:0]       pipex_dp_ex3_vfalu_freg_data,
  input  logic [4:0]        pipex_dp_ex3_vfalu_ereg_data,
  input  logic              vfpu_wb_pipe7_grant,
  output logic              pipe7_wb_vld,
  output logic [PREG_W-1:0] pipe7_wb_preg,
  output logic [IID_W-1:0]  pipe7_wb_iid,
  output logic              pipe7_wb_freg_wen,
  output logic [63:0]       pipe7_wb_data,
  output logic              pipe7_wb_ereg_vld,
  output logic [4:0]        pipe7_wb_ereg,
  output logic              pipe7_issue_rdy
);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int OCC_W   = CNT_W + 2;
  localparam int ENTRY_W = wb_entry_w(PREG_W, IID_W);

  typedef struct packed {
    logic [PREG_W-1:0] preg;
    logic [IID_W-1:0]  iid;
    logic              freg_wen;
    logic              ereg_wen;
  } ctrl_t;

  typedef struct packed {
    ctrl_t             ctrl;
    logic [63:0]       data;
    logic [EREG_W-1:0] ereg;
  } entry_t;

  // vld_pipe_q[2] = EX2 valid, vld_pipe_q[3] = EX3 valid
  logic [3:2]  vld_pipe_q, vld_pipe_d;
  ctrl_t [3:2] ctrl_q;
  ctrl_t       ex1_ctrl;

  entry_t           push_entry, head;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full, fifo_empty, wb_pop;
  logic [OCC_W-1:0] occupancy;

  assign ex1_ctrl = '{preg:     dp_vfalu_ex1_pipex_preg,
                      iid:      dp_vfalu_ex1_pipex_iid,
                      freg_wen: dp_vfalu_ex1_pipex_freg_wen,
                      ereg_wen: dp_vfalu_ex1_pipex_ereg_wen};

  // Flush kills EX1 (never enters EX2) and EX2 (never enters EX3).
  always_comb begin
    vld_pipe_d    = '0;
    vld_pipe_d[2] = dp_vfalu_ex1_pipex_inst_vld & ~rtu_yy_xx_flush;
    vld_pipe_d[3] = vld_pipe_q[2] & ~rtu_yy_xx_flush;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      vld_pipe_q <= '0;
      ctrl_q     <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      if (dp_vfalu_ex1_pipex_inst_vld) ctrl_q[2] <= ex1_ctrl;
      if (vld_pipe_q[2])               ctrl_q[3] <= ctrl_q[2];
    end
  end

  assign push_entry = '{ctrl: ctrl_q[3],
                        data: pipex_dp_ex3_vfalu_freg_data,
                        ereg: pipex_dp_ex3_vfalu_ereg_data};
  assign wb_pop     = pipe7_wb_vld & vfpu_wb_pipe7_grant;

  ct_vfalu_wb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk_i   (forever_cpuclk),
    .rst_b_i (cpurst_b),
    .flush_i (rtu_yy_xx_flush),
    .push_i  (vld_pipe_q[3]),
    .din_i   (push_entry),
    .pop_i   (wb_pop),
    .dout_o  (head),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Every op already past the issue point will land in the FIFO since the
  // EX pipe cannot stall, so it has to be reserved before a new one issues.
  assign occupancy = OCC_W'(fifo_cnt) + OCC_W'(dp_vfalu_ex1_pipex_inst_vld)
                   + OCC_W'(vld_pipe_q[2]) + OCC_W'(vld_pipe_q[3]);
  assign pipe7_issue_rdy = (occupancy < OCC_W'(DEPTH));

  assign pipe7_wb_vld      = ~fifo_empty;
  assign pipe7_wb_preg     = head.ctrl.preg;
  assign pipe7_wb_iid      = head.ctrl.iid;
  assign pipe7_wb_freg_wen = head.ctrl.freg_wen;
  assign pipe7_wb_data     = head.data;
  assign pipe7_wb_ereg_vld = head.ctrl.ereg_wen;
  assign pipe7_wb_ereg     = {head.ereg[EREG_NV], head.ereg[EREG_DZ], head.ereg[EREG_OF],
                              head.ereg[EREG_UF], head.ereg[EREG_NX]};

  // The credit scheme must make a push into a full FIFO unreachable.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst_b && !rtu_yy_xx_flush) assert (!(vld_pipe_q[3] && fifo_full));
  end
endmodule

// File: tb/tb_ct_vfalu_wb_pipe7.sv
module tb_ct_vfalu_wb_pipe7;
  logic        clk = 1'b0;
  logic        cpurst_b = 1'b0;
  logic        flush = 1'b0;
  logic        inst_vld = 1'b0;
  logic [6:0]  preg_in = '0, iid_in = '0;
  logic        fw_in = 1'b0, ew_in = 1'b0;
  logic [63:0] freg_data = '0;
  logic [4:0]  ereg_data = '0;
  logic        grant = 1'b0;
  logic        wb_vld, wb_fw, wb_ev, issue_rdy;
  logic [6:0]  wb_preg, wb_iid;
  logic [63:0] wb_data;
  logic [4:0]  wb_ereg;

  always #5 clk = ~clk;

  ct_vfalu_wb_pipe7 #(.DEPTH(4), .PREG_W(7), .IID_W(7)) dut (
    .forever_cpuclk               (clk),
    .cpurst_b                     (cpurst_b),
    .rtu_yy_xx_flush              (flush),
    .dp_vfalu_ex1_pipex_inst_vld  (inst_vld),
    .dp_vfalu_ex1_pipex_preg      (preg_in),
    .dp_vfalu_ex1_pipex_iid       (iid_in),
    .dp_vfalu_ex1_pipex_freg_wen  (fw_in),
    .dp_vfalu_ex1_pipex_ereg_wen  (ew_in),
    .pipex_dp_ex3_vfalu_freg_data (freg_data),
    .pipex_dp_ex3_vfalu_ereg_data (ereg_data),
    .vfpu_wb_pipe7_grant          (grant),
    .pipe7_wb_vld                 (wb_vld),
    .pipe7_wb_preg                (wb_preg),
    .pipe7_wb_iid                 (wb_iid),
    .pipe7_wb_freg_wen            (wb_fw),
    .pipe7_wb_data                (wb_data),
    .pipe7_wb_ereg_vld            (wb_ev),
    .pipe7_wb_ereg                (wb_ereg),
    .pipe7_issue_rdy              (issue_rdy)
  );

  typedef struct {
    bit [6:0]  preg;
    bit [6:0]  iid;
    bit        fw;
    bit        ew;
    bit [63:0] data;
    bit [4:0]  ereg;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;
  bit   rdy_last = 1'b0;
  bit   g_rst = 1'b0, g_flush = 1'b0, g_grant = 1'b0;
  bit [63:0] pd0 = '0, pd1 = '0;
  bit [4:0]  pe0 = '0, pe1 = '0;

  // One clock cycle: apply controls shortly after the edge, feed EX3 with
  // the result of the op issued two cycles ago, then stop at the negedge.
  task automatic tick(input bit v, input bit [6:0] p, input bit [6:0] id,
                      input bit fw, input bit ew, input bit [63:0] d, input bit [4:0] e);
    exp_t x;
    @(posedge clk); #1;
    cpurst_b = g_rst; flush = g_flush; grant = g_grant;
    inst_vld = v; preg_in = p; iid_in = id; fw_in = fw; ew_in = ew;
    freg_data = pd1; ereg_data = pe1;
    pd1 = pd0; pe1 = pe0;
    pd0 = v ? d : {$urandom, $urandom};
    pe0 = v ? e : 5'($urandom);
    if (v) begin
      x = '{p, id, fw, ew, d, e};
      q.push_back(x);
    end
    @(negedge clk);
    rdy_last = issue_rdy;
  endtask

  task automatic idle();
    tick(1'b0, 7'h0, 7'h0, 1'b0, 1'b0, 64'h0, 5'h0);
  endtask

  // Scoreboard: queue holds every issued, not-yet-retired op in order, so
  // its size before this cycle's pop equals FIFO count + ops in flight.
  always @(negedge clk) begin
    exp_t e;
    if (!cpurst_b) begin
      q.delete();
    end else begin
      vectors++;
      if (issue_rdy !== (q.size() < 4)) begin
        errors++;
        $display("FAIL issue_rdy: got %b want %b (queued %0d)", issue_rdy, q.size() < 4, q.size());
      end
      if (wb_vld === 1'b1) begin
        vectors++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wb: got iid %h want no valid entry", wb_iid);
        end else begin
          e = q[0];
          if ({wb_preg, wb_iid, wb_fw, wb_ev, wb_data, wb_ereg} !==
              {e.preg, e.iid, e.fw, e.ew, e.data, e.ereg}) begin
            errors++;
            $display("FAIL wb_head: got preg %h iid %h fw %b ev %b data %h ereg %h want preg %h iid %h fw %b ev %b data %h ereg %h",
                     wb_preg, wb_iid, wb_fw, wb_ev, wb_data, wb_ereg,
                     e.preg, e.iid, e.fw, e.ew, e.data, e.ereg);
          end
          if (grant) void'(q.pop_front());
        end
      end else if (wb_vld !== 1'b0) begin
        vectors++;
        errors++;
        $display("FAIL wb_vld_x: got %b want 0/1", wb_vld);
      end
      if (flush) q.delete();
    end
  end

  task automatic test_reset();
    g_rst = 1'b0; g_flush = 1'b0; g_grant = 1'b0;
    idle(); idle();
    vectors++;
    if ({wb_vld, issue_rdy, wb_preg, wb_iid, wb_data, wb_ereg, wb_fw, wb_ev} !== {1'b0, 1'b1, 7'h0, 7'h0, 64'h0, 5'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got vld %b rdy %b data %h want vld 0 rdy 1 data 0", wb_vld, issue_rdy, wb_data);
    end
    g_rst = 1'b1;
    idle();
  endtask

  task automatic test_single();
    bit [3:0] seen;
    g_grant = 1'b1;
    tick(1'b1, 7'h15, 7'h03, 1'b1, 1'b1, 64'h3FF0000000000000, 5'h01);
    seen[0] = wb_vld;
    idle(); seen[1] = wb_vld;
    idle(); seen[2] = wb_vld;
    idle(); seen[3] = wb_vld;
    vectors++;
    if (seen !== 4'b1000) begin
      errors++;
      $display("FAIL single_latency: got vld t..t+3 %b want 1000", {seen[0], seen[1], seen[2], seen[3]});
    end
    vectors++;
    if ({wb_preg, wb_iid, wb_fw, wb_data, wb_ev, wb_ereg} !== {7'h15, 7'h03, 1'b1, 64'h3FF0000000000000, 1'b1, 5'h01}) begin
      errors++;
      $display("FAIL single_value: got preg %h iid %h data %h ereg %h want 15 03 3ff0000000000000 01", wb_preg, wb_iid, wb_data, wb_ereg);
    end
    idle();
    vectors++;
    if (wb_vld !== 1'b0) begin
      errors++;
      $display("FAIL single_one_cycle: got vld %b want 0", wb_vld);
    end
  endtask

  task automatic test_backpressure();
    bit [6:0] next_iid;
    g_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 7'(8'h20 + i), 7'(i), 1'b1, 1'b0, {$urandom, $urandom}, 5'($urandom));
      vectors++;
      if (issue_rdy !== (i < 3)) begin
        errors++;
        $display("FAIL bp_rdy_op%0d: got %b want %b", i, issue_rdy, i < 3);
      end
    end
    idle(); idle(); idle();
    vectors++;
    if ({wb_vld, wb_iid, issue_rdy} !== {1'b1, 7'h00, 1'b0}) begin
      errors++;
      $display("FAIL bp_full: got vld %b iid %h rdy %b want 1 00 0", wb_vld, wb_iid, issue_rdy);
    end
    g_grant = 1'b1;
    next_iid = 7'h0;
    for (int c = 0; c < 6; c++) begin
      idle();
      if (wb_vld) begin
        vectors++;
        if (wb_iid !== next_iid) begin
          errors++;
          $display("FAIL bp_order: got iid %h want %h", wb_iid, next_iid);
        end
        next_iid++;
      end
    end
    vectors++;
    if ({next_iid, wb_vld, issue_rdy} !== {7'd4, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL bp_drain: got retired %0d vld %b rdy %b want 4 0 1", next_iid, wb_vld, issue_rdy);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    // Park two entries, then stream with grant high so pushes and pops overlap.
    g_grant = 1'b0;
    tick(1'b1, 7'h30, 7'h40, 1'b1, 1'b0, 64'h1111_2222_3333_4444, 5'h02);
    tick(1'b1, 7'h31, 7'h41, 1'b1, 1'b1, 64'h5555_6666_7777_8888, 5'h04);
    idle(); idle(); idle();
    g_grant = 1'b1;
    n = 0;
    for (int c = 0; c < 80 && n < 10; c++) begin
      if (rdy_last) begin
        tick(1'b1, 7'(8'h32 + n), 7'(8'h42 + n), 1'b1, n[0], {$urandom, $urandom}, 5'($urandom));
        n++;
      end else idle();
    end
    for (int c = 0; c < 8; c++) idle();
    // Random grant and issue pattern exercises head hold and pointer wrap.
    n = 0;
    for (int c = 0; c < 200; c++) begin
      g_grant = 1'($urandom_range(0, 1));
      if (rdy_last && n < 24 && $urandom_range(0, 3) != 0) begin
        tick(1'b1, 7'($urandom), 7'(8'h50 + n), 1'($urandom), 1'($urandom), {$urandom, $urandom}, 5'($urandom));
        n++;
      end else idle();
    end
    g_grant = 1'b1;
    for (int c = 0; c < 8; c++) idle();
    vectors++;
    if (q.size() != 0 || n != 24) begin
      errors++;
      $display("FAIL b2b_drain: got %0d pending %0d issued want 0 pending 24 issued", q.size(), n);
    end
  endtask

  task automatic test_flush();
    bit leaked;
    g_grant = 1'b0;
    tick(1'b1, 7'h01, 7'h60, 1'b1, 1'b0, 64'hA, 5'h0);
    tick(1'b1, 7'h02, 7'h61, 1'b1, 1'b0, 64'hB, 5'h0);
    idle(); idle(); idle();
    tick(1'b1, 7'h03, 7'h62, 1'b1, 1'b0, 64'hC, 5'h0);
    tick(1'b1, 7'h04, 7'h63, 1'b1, 1'b0, 64'hD, 5'h0);
    g_flush = 1'b1; g_grant = 1'b1;
    idle();
    g_flush = 1'b0;
    idle();
    vectors++;
    if ({wb_vld, issue_rdy} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL flush_next: got vld %b rdy %b want 0 1", wb_vld, issue_rdy);
    end
    leaked = 1'b0;
    for (int c = 0; c < 6; c++) begin
      idle();
      if (wb_vld !== 1'b0) leaked = 1'b1;
    end
    vectors++;
    if (leaked) begin
      errors++;
      $display("FAIL flush_leak: got flushed entry on wb want none");
    end
  endtask

  task automatic test_reset_mid();
    bit [3:0] seen;
    g_grant = 1'b0;
    for (int i = 0; i < 4; i++)
      tick(1'b1, 7'(8'h10 + i), 7'(8'h70 + i), 1'b1, 1'b0, {$urandom, $urandom}, 5'h0);
    idle(); idle(); idle();
    vectors++;
    if ({wb_vld, issue_rdy} !== {1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rst_full: got vld %b rdy %b want 1 0", wb_vld, issue_rdy);
    end
    g_rst = 1'b0;
    idle();
    g_rst = 1'b1;
    idle();
    vectors++;
    if ({wb_vld, issue_rdy} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid_clear: got vld %b rdy %b want 0 1", wb_vld, issue_rdy);
    end
    g_grant = 1'b1;
    tick(1'b1, 7'h7E, 7'h7D, 1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001, 5'h03);
    seen[0] = wb_vld;
    idle(); seen[1] = wb_vld;
    idle(); seen[2] = wb_vld;
    idle(); seen[3] = wb_vld;
    vectors++;
    if (seen !== 4'b1000 || wb_iid !== 7'h7D) begin
      errors++;
      $display("FAIL rst_after_op: got vld t..t+3 %b iid %h want 1000 7d", {seen[0], seen[1], seen[2], seen[3]}, wb_iid);
    end
    idle();
  endtask

  task automatic test_ereg_only();
    g_grant = 1'b1;
    tick(1'b1, 7'h33, 7'h2A, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 5'h10);
    idle(); idle(); idle();
    vectors++;
    if ({wb_vld, wb_fw, wb_ev, wb_ereg} !== {1'b1, 1'b0, 1'b1, 5'h10}) begin
      errors++;
      $display("FAIL ereg_only: got vld %b fw %b ev %b ereg %h want 1 0 1 10", wb_vld, wb_fw, wb_ev, wb_ereg);
    end
    idle(); idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_ereg_only();
    vectors++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL final_drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/ct_vfalu_wb_pipe7.md
Name: ct_vfalu_wb_pipe7

Overview:
- Writeback stage directly downstream of the pipe-7 VFALU datapath.
- Tracks each EX1-issued op's control (valid, dest preg, iid, write-enables) through EX2/EX3, pairs it with the EX3 freg/ereg result, and queues it in an in-order FIFO.
- Drains the FIFO to the shared FP register-file write port under a valid/grant handshake.
- Issue backpressure is credit-based because the EX1-EX3 pipe cannot stall.

Parameters:
DEPTH, 4, writeback FIFO entries (power of 2, >= 4)
PREG_W, 7, physical register tag width
IID_W, 7, instruction id width

Ports:
forever_cpuclk  in  1  clock
cpurst_b  in  1  synchronous active-low reset
rtu_yy_xx_flush  in  1  pipeline flush
dp_vfalu_ex1_pipex_inst_vld  in  1  op issued into EX1 this cycle
dp_vfalu_ex1_pipex_preg  in  PREG_W  destination preg
dp_vfalu_ex1_pipex_iid  in  IID_W  instruction id
dp_vfalu_ex1_pipex_freg_wen  in  1  op writes FP result
dp_vfalu_ex1_pipex_ereg_wen  in  1  op writes fflags
pipex_dp_ex3_vfalu_freg_data  in  64  EX3 FP result
pipex_dp_ex3_vfalu_ereg_data  in  5  EX3 fflags (NV,DZ,OF,UF,NX)
vfpu_wb_pipe7_grant  in  1  write port accepts head entry
pipe7_wb_vld  out  1  head entry valid
pipe7_wb_preg  out  PREG_W  head dest preg
pipe7_wb_iid  out  IID_W  head iid
pipe7_wb_freg_wen  out  1  head writes FP reg
pipe7_wb_data  out  64  head FP data
pipe7_wb_ereg_vld  out  1  head writes fflags
pipe7_wb_ereg  out  5  head fflags
pipe7_issue_rdy  out  1  EX1 may accept an op next cycle

Behaviour:
- Single clock forever_cpuclk. All state resets synchronously when cpurst_b==0: ex2/ex3 valids=0, FIFO rd/wr ptr=0, count=0. Outputs after reset: pipe7_wb_vld=0, pipe7_issue_rdy=1. Data outputs are don't-care while wb_vld=0 but reset to 0.
- Control pipe: EX1 ctrl is registered to EX2, then to EX3 (valid, preg, iid, freg_wen, ereg_wen). Data fields load only when the stage valid is set.
- Push: at the EX3 clock edge, if ex3_vld, write {ctrl, freg_data, ereg_data} to FIFO[wr_ptr].
- Latency: op in EX1 at cycle t with empty FIFO gives pipe7_wb_vld=1 in cycle t+3 (EX4), driven from FIFO head registers. There is no combinational EX3->wb bypass.
- Handshake: pop when pipe7_wb_vld && vfpu_wb_pipe7_grant. The head must hold stable while vld && !grant. Grant while vld=0 is ignored.
- Simultaneous push and pop: count unchanged, both pointers advance. Push while full: this is an assertion failure, and credit logic must make it unreachable.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Credit: inflight = ex1_inst_vld + ex2_vld + ex3_vld. pipe7_issue_rdy = (count + inflight) < DEPTH, computed from the current-cycle count before pop.
- Flush (rtu_yy_xx_flush=1): next cycle ex2/ex3 valids=0, pointers and count=0, pipe7_wb_vld=0. Flush beats a same-cycle push and pop; a pop granted in the flush cycle still counts as a completed write. EX1 valid in the flush cycle is dropped.
- Reset mid-operation: identical to flush. No partial writes are retained.
- ereg: pipe7_wb_ereg_vld = head ereg_wen. pipe7_wb_ereg passes through unmodified and is not accumulated here.

Decomposition:
- Shared package ct_vfalu_pkg: ereg bit-position constants (NV=4..NX=0), FIFO entry struct width (PREG_W+IID_W+2+64+5), default DEPTH.
- One sub-module, ct_vfalu_wb_fifo: a parameterised synchronous FIFO with push/pop/flush, count and full/empty, and a registered head.
- The control pipe stays in the top module.

Test Plan:
- Single op: preg=0x15, iid=0x03, freg_wen=1, data=0x3FF0000000000000, ereg=0x01, grant held 1 -> wb_vld rises exactly at t+3 with those values, for one cycle.
- Backpressure: 4 back-to-back ops with grant=0 -> issue_rdy drops as soon as count+inflight reaches 4. Raising grant -> entries drain in issue order (iids 0,1,2,3) and issue_rdy returns 1.
- Simultaneous push and pop with FIFO at count=2 and grant=1 -> count stays 2, pointers wrap correctly past DEPTH-1 over 10 ops, no data corruption.
- Flush with 2 entries buffered and 2 ops in EX2/EX3 -> next cycle wb_vld=0, count=0, issue_rdy=1. No flushed iid ever appears on wb.
- Reset asserted with FIFO full and grant=0 -> all valids clear the following edge. After reset release, a new op appears at t+3.
- ereg-only op (freg_wen=0, ereg_wen=1, ereg=0x10) -> wb_freg_wen=0, wb_ereg_vld=1, wb_ereg=0x10.
